// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control unit: opcodes, ALUOp classes
// and the packed control bundle carried into ID/EX.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_R   = 3'b000;
   localparam logic [2:0] ALUOP_ADD = 3'b100;
   localparam logic [2:0] ALUOP_SLT = 3'b010;
   localparam logic [2:0] ALUOP_SUB = 3'b001;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic       branch_ne;
      logic       jump;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic [2:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/op_decode_comb.sv
// Purely combinational opcode table: control bundle, source-register usage
// and an illegal-opcode flag (unknown opcodes decode to a NOP).
module op_decode_comb
   import ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] op,
   output ctrl_t           ctrl,
   output logic            rs_used,
   output logic            rt_used,
   output logic            illegal
);

   always_comb begin
      ctrl    = '0;
      rs_used = 1'b1;
      rt_used = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_W'(OP_RTYPE): begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            ctrl.alu_op    = ALUOP_R;
            rt_used        = 1'b1;
         end
         OP_W'(OP_ADDI): begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
         end
         OP_W'(OP_SLTI): begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALUOP_SLT;
         end
         OP_W'(OP_LW): begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_op     = ALUOP_ADD;
         end
         OP_W'(OP_SW): begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
            rt_used        = 1'b1;
         end
         OP_W'(OP_BEQ): begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALUOP_SUB;
            rt_used     = 1'b1;
         end
         OP_W'(OP_BNE): begin
            ctrl.branch    = 1'b1;
            ctrl.branch_ne = 1'b1;
            ctrl.alu_op    = ALUOP_SUB;
            rt_used        = 1'b1;
         end
         OP_W'(OP_J): begin
            ctrl.jump = 1'b1;
            rs_used   = 1'b0;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// ID-stage control: decodes IF/ID, registers controls into ID/EX, detects
// load-use hazards against the EX entry and counts stall cycles.
module pipe_ctrl_decoder
   import ctrl_pkg::*;
#(
   parameter int OP_W      = 6,
   parameter int ALUOP_W   = 3,
   parameter int REG_W     = 5,
   parameter int CNT_W     = 16,
   parameter bit HAZARD_EN = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [OP_W-1:0]    instr_op_i,
   input  logic [REG_W-1:0]   rs_i,
   input  logic [REG_W-1:0]   rt_i,
   input  logic [REG_W-1:0]   rd_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               valid_o,
   output logic               RegWrite_o,
   output logic               ALUSrc_o,
   output logic               RegDst_o,
   output logic               Branch_o,
   output logic               BranchNe_o,
   output logic               Jump_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic               MemtoReg_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic [REG_W-1:0]   wr_reg_o,
   output logic               illegal_o,
   output logic [CNT_W-1:0]   stall_cnt_o
);

   ctrl_t            dec_ctrl;
   logic             dec_rs_used;
   logic             dec_rt_used;
   logic             dec_illegal;

   ctrl_t            ctrl_reg,    ctrl_next;
   logic             valid_reg,   valid_next;
   logic             illegal_reg, illegal_next;
   logic [REG_W-1:0] wr_reg_reg,  wr_reg_next;
   logic [CNT_W-1:0] cnt_reg,     cnt_next;
   logic             hazard;

   op_decode_comb #(.OP_W(OP_W)) u_op_decode (
      .op      (instr_op_i),
      .ctrl    (dec_ctrl),
      .rs_used (dec_rs_used),
      .rt_used (dec_rt_used),
      .illegal (dec_illegal)
   );

   // $0 is never a real producer, so a load into it cannot stall.
   generate
      if (HAZARD_EN) begin : g_hazard
         assign hazard = valid_i & valid_reg & ctrl_reg.mem_read &
                         (wr_reg_reg != '0) &
                         ((dec_rs_used & (rs_i == wr_reg_reg)) |
                          (dec_rt_used & (rt_i == wr_reg_reg))) &
                         ~flush_i;
      end else begin : g_no_hazard
         assign hazard = 1'b0;
      end
   endgenerate

   always_comb begin
      ctrl_next    = '0;
      valid_next   = 1'b0;
      illegal_next = 1'b0;
      wr_reg_next  = '0;
      cnt_next     = cnt_reg;
      if (hazard && (cnt_reg != '1)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
      if (valid_i && !flush_i && !hazard) begin
         ctrl_next    = dec_ctrl;
         valid_next   = 1'b1;
         illegal_next = dec_illegal;
         wr_reg_next  = dec_ctrl.reg_dst ? rd_i : rt_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_reg    <= '0;
         valid_reg   <= 1'b0;
         illegal_reg <= 1'b0;
         wr_reg_reg  <= '0;
         cnt_reg     <= '0;
      end else begin
         ctrl_reg    <= ctrl_next;
         valid_reg   <= valid_next;
         illegal_reg <= illegal_next;
         wr_reg_reg  <= wr_reg_next;
         cnt_reg     <= cnt_next;
      end
   end

   assign stall_o     = hazard;
   assign valid_o     = valid_reg;
   assign RegWrite_o  = ctrl_reg.reg_write;
   assign ALUSrc_o    = ctrl_reg.alu_src;
   assign RegDst_o    = ctrl_reg.reg_dst;
   assign Branch_o    = ctrl_reg.branch;
   assign BranchNe_o  = ctrl_reg.branch_ne;
   assign Jump_o      = ctrl_reg.jump;
   assign MemRead_o   = ctrl_reg.mem_read;
   assign MemWrite_o  = ctrl_reg.mem_write;
   assign MemtoReg_o  = ctrl_reg.mem_to_reg;
   assign ALUOp_o     = ALUOP_W'(ctrl_reg.alu_op);
   assign wr_reg_o    = wr_reg_reg;
   assign illegal_o   = illegal_reg;
   assign stall_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Scoreboard bench for pipe_ctrl_decoder: a reference model pushes the
// expected ID/EX contents per driven instruction; each test pops after the edge.
module tb_pipe_ctrl_decoder;

   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] SLTI = 6'b001010;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       valid_i = 1'b0;
   logic       flush_i = 1'b0;
   logic [5:0] instr_op_i = '0;
   logic [4:0] rs_i = '0;
   logic [4:0] rt_i = '0;
   logic [4:0] rd_i = '0;

   logic        stall_o, valid_o, RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o;
   logic        Jump_o, MemRead_o, MemWrite_o, MemtoReg_o, illegal_o;
   logic [2:0]  ALUOp_o;
   logic [4:0]  wr_reg_o;
   logic [15:0] stall_cnt_o;

   logic        d2_stall, d2_valid, d2_rw, d2_as, d2_rd, d2_br, d2_bne, d2_j, d2_mr, d2_mw, d2_m2r, d2_ill;
   logic [2:0]  d2_aluop;
   logic [4:0]  d2_wr;
   logic [1:0]  d2_cnt;

   always #5 clk = ~clk;

   pipe_ctrl_decoder dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .instr_op_i(instr_op_i),
      .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i),
      .stall_o(stall_o), .valid_o(valid_o), .RegWrite_o(RegWrite_o), .ALUSrc_o(ALUSrc_o),
      .RegDst_o(RegDst_o), .Branch_o(Branch_o), .BranchNe_o(BranchNe_o), .Jump_o(Jump_o),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
      .ALUOp_o(ALUOp_o), .wr_reg_o(wr_reg_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
   );

   pipe_ctrl_decoder #(.CNT_W(2)) dut_cnt2 (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .instr_op_i(instr_op_i),
      .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i),
      .stall_o(d2_stall), .valid_o(d2_valid), .RegWrite_o(d2_rw), .ALUSrc_o(d2_as),
      .RegDst_o(d2_rd), .Branch_o(d2_br), .BranchNe_o(d2_bne), .Jump_o(d2_j),
      .MemRead_o(d2_mr), .MemWrite_o(d2_mw), .MemtoReg_o(d2_m2r),
      .ALUOp_o(d2_aluop), .wr_reg_o(d2_wr), .illegal_o(d2_ill), .stall_cnt_o(d2_cnt)
   );

   typedef struct packed {
      logic v; logic [5:0] op; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic fl;
   } stim_t;

   // c = {RegWrite, ALUSrc, RegDst, Branch, BranchNe, Jump, MemRead, MemWrite, MemtoReg, ALUOp[2:0]}
   typedef struct packed {
      logic valid; logic [11:0] c; logic [4:0] wr; logic ill; logic [15:0] cnt; logic [1:0] cnt2;
   } exp_t;

   typedef struct packed { logic [11:0] c; logic rsu; logic rtu; logic ill; } mdec_t;

   exp_t m;
   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   function automatic stim_t mk(input logic v, input logic [5:0] op, input int rs,
                                input int rt, input int rd, input logic fl);
      stim_t s;
      s.v = v; s.op = op; s.rs = rs[4:0]; s.rt = rt[4:0]; s.rd = rd[4:0]; s.fl = fl;
      return s;
   endfunction

   function automatic mdec_t decode_model(input logic [5:0] op);
      mdec_t d;
      d.rsu = 1'b1; d.rtu = 1'b0; d.ill = 1'b0;
      case (op)
         RT:   begin d.c = 12'b101_000_000_000; d.rtu = 1'b1; end
         ADDI: d.c = 12'b110_000_000_100;
         SLTI: d.c = 12'b110_000_000_010;
         LW:   d.c = 12'b110_000_101_100;
         SW:   begin d.c = 12'b010_000_010_100; d.rtu = 1'b1; end
         BEQ:  begin d.c = 12'b000_100_000_001; d.rtu = 1'b1; end
         BNE:  begin d.c = 12'b000_110_000_001; d.rtu = 1'b1; end
         JMP:  begin d.c = 12'b000_001_000_000; d.rsu = 1'b0; end
         default: begin d.c = '0; d.ill = 1'b1; end
      endcase
      return d;
   endfunction

   function automatic exp_t act();
      return {valid_o, RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, Jump_o,
              MemRead_o, MemWrite_o, MemtoReg_o, ALUOp_o, wr_reg_o, illegal_o,
              stall_cnt_o, d2_cnt};
   endfunction

   // Applies one ID-stage input set, advances the model, queues its next ID/EX state.
   task automatic drive(input stim_t s, output logic exp_stall);
      mdec_t d;
      exp_t  nx;
      valid_i = s.v; instr_op_i = s.op; rs_i = s.rs; rt_i = s.rt; rd_i = s.rd; flush_i = s.fl;
      d = decode_model(s.op);
      exp_stall = s.v && !s.fl && m.valid && m.c[5] && (m.wr != 5'd0) &&
                  ((d.rsu && s.rs == m.wr) || (d.rtu && s.rt == m.wr));
      nx = '0;
      nx.cnt  = (exp_stall && m.cnt != 16'hFFFF) ? m.cnt + 16'd1 : m.cnt;
      nx.cnt2 = (exp_stall && m.cnt2 != 2'd3) ? m.cnt2 + 2'd1 : m.cnt2;
      if (s.v && !s.fl && !exp_stall) begin
         nx.valid = 1'b1;
         nx.c     = d.c;
         nx.wr    = d.c[9] ? s.rd : s.rt;
         nx.ill   = d.ill;
      end
      m = nx;
      sb.push_back(nx);
   endtask

   task automatic apply_reset();
      #2 rst_i = 1'b0;
      m = '0;
      sb.delete();
      @(negedge clk);
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      logic es;
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if ({act(), stall_o} !== '0) begin
         fails++; $display("FAIL reset_state: got %h stall %b, expected all zero", act(), stall_o);
      end
      @(negedge clk); rst_i = 1'b1; m = '0;
      drive(mk(1, ADDI, 1, 2, 0, 0), es);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (act() !== e) begin
         fails++; $display("FAIL reset_pre_valid: got %h expected %h", act(), e);
      end
      #2 rst_i = 1'b0;
      #1;
      checks++;
      if (act() !== '0 || stall_o !== 1'b0) begin
         fails++; $display("FAIL reset_async: got %h stall %b, expected all zero", act(), stall_o);
      end
      m = '0; sb.delete();
      @(negedge clk); rst_i = 1'b1;
      drive(mk(1, LW, 0, 8, 0, 0), es);
      @(posedge clk); #1;
      e = sb.pop_front();
      drive(mk(1, RT, 8, 1, 9, 0), es);
      #1;
      checks++;
      if (stall_o !== 1'b1) begin
         fails++; $display("FAIL reset_stall_setup: got stall %b expected 1", stall_o);
      end
      #1 rst_i = 1'b0;
      #1;
      checks++;
      if (stall_o !== 1'b0 || act() !== '0) begin
         fails++; $display("FAIL reset_mid_stall: got stall %b outs %h, expected 0", stall_o, act());
      end
      m = '0; sb.delete();
      @(negedge clk); rst_i = 1'b1;
   endtask

   task automatic test_load_use();
      stim_t l[$];
      exp_t  e;
      logic  es;
      l.push_back(mk(1, LW, 0, 8, 0, 0));
      l.push_back(mk(1, RT, 8, 1, 9, 0));
      l.push_back(mk(1, RT, 8, 1, 9, 0));
      l.push_back(mk(1, LW, 0, 0, 0, 0));
      l.push_back(mk(1, RT, 0, 0, 9, 0));
      foreach (l[i]) begin
         drive(l[i], es);
         #1; checks++;
         if (stall_o !== es) begin
            fails++; $display("FAIL load_use[%0d] stall_o: got %b expected %b", i, stall_o, es);
         end
         @(posedge clk); #1; checks++;
         if (sb.size() == 0) begin
            fails++; $display("FAIL load_use[%0d] scoreboard: got empty queue expected entry", i);
         end else begin
            e = sb.pop_front();
            if (act() !== e) begin
               fails++; $display("FAIL load_use[%0d] outputs: got %h expected %h", i, act(), e);
            end
         end
      end
   endtask

   task automatic test_rt_and_jump();
      stim_t l[$];
      exp_t  e;
      logic  es;
      l.push_back(mk(1, LW, 0, 8, 0, 0));
      l.push_back(mk(1, SW, 3, 8, 0, 0));
      l.push_back(mk(1, SW, 3, 8, 0, 0));
      l.push_back(mk(1, LW, 0, 8, 0, 0));
      l.push_back(mk(1, JMP, 8, 8, 8, 0));
      l.push_back(mk(1, LW, 2, 7, 0, 0));
      l.push_back(mk(1, BNE, 7, 4, 0, 0));
      l.push_back(mk(1, BNE, 7, 4, 0, 0));
      foreach (l[i]) begin
         drive(l[i], es);
         #1; checks++;
         if (stall_o !== es) begin
            fails++; $display("FAIL rt_jump[%0d] stall_o: got %b expected %b", i, stall_o, es);
         end
         @(posedge clk); #1; checks++;
         if (sb.size() == 0) begin
            fails++; $display("FAIL rt_jump[%0d] scoreboard: got empty queue expected entry", i);
         end else begin
            e = sb.pop_front();
            if (act() !== e) begin
               fails++; $display("FAIL rt_jump[%0d] outputs: got %h expected %h", i, act(), e);
            end
         end
      end
   endtask

   task automatic test_flush();
      stim_t l[$];
      exp_t  e;
      logic  es;
      l.push_back(mk(1, LW, 0, 8, 0, 0));
      l.push_back(mk(1, RT, 8, 1, 9, 1));
      l.push_back(mk(1, RT, 8, 1, 9, 0));
      l.push_back(mk(1, ADDI, 1, 5, 0, 1));
      l.push_back(mk(0, ADDI, 1, 5, 0, 0));
      foreach (l[i]) begin
         drive(l[i], es);
         #1; checks++;
         if (stall_o !== es) begin
            fails++; $display("FAIL flush[%0d] stall_o: got %b expected %b", i, stall_o, es);
         end
         @(posedge clk); #1; checks++;
         if (sb.size() == 0) begin
            fails++; $display("FAIL flush[%0d] scoreboard: got empty queue expected entry", i);
         end else begin
            e = sb.pop_front();
            if (act() !== e) begin
               fails++; $display("FAIL flush[%0d] outputs: got %h expected %h", i, act(), e);
            end
         end
      end
   endtask

   task automatic test_decode();
      stim_t l[$];
      exp_t  e;
      logic  es;
      l.push_back(mk(1, RT,   1, 2, 3, 0));
      l.push_back(mk(1, ADDI, 1, 4, 3, 0));
      l.push_back(mk(1, SLTI, 1, 5, 3, 0));
      l.push_back(mk(1, SW,   1, 6, 3, 0));
      l.push_back(mk(1, BEQ,  1, 7, 3, 0));
      l.push_back(mk(1, BNE,  1, 9, 3, 0));
      l.push_back(mk(1, JMP,  1, 10, 3, 0));
      l.push_back(mk(1, BAD,  1, 11, 3, 0));
      l.push_back(mk(1, RT,   1, 12, 13, 0));
      l.push_back(mk(1, LW,   1, 14, 3, 0));
      l.push_back(mk(1, JMP,  14, 14, 14, 0));
      foreach (l[i]) begin
         drive(l[i], es);
         #1; checks++;
         if (stall_o !== es) begin
            fails++; $display("FAIL decode[%0d] stall_o: got %b expected %b", i, stall_o, es);
         end
         @(posedge clk); #1; checks++;
         if (sb.size() == 0) begin
            fails++; $display("FAIL decode[%0d] scoreboard: got empty queue expected entry", i);
         end else begin
            e = sb.pop_front();
            if (act() !== e) begin
               fails++; $display("FAIL decode[%0d] outputs: got %h expected %h", i, act(), e);
            end
         end
         if (l[i].op == BNE) begin
            checks++;
            if ({Branch_o, BranchNe_o, ALUOp_o} !== 5'b11_001) begin
               fails++; $display("FAIL decode_bne: got %b expected 11001", {Branch_o, BranchNe_o, ALUOp_o});
            end
         end
         if (l[i].op == BAD) begin
            checks++;
            if ({valid_o, illegal_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o} !== 7'b1100000) begin
               fails++; $display("FAIL decode_illegal: got %b expected 1100000",
                                 {valid_o, illegal_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o});
            end
         end
      end
   endtask

   task automatic test_saturation();
      stim_t l[$];
      exp_t  e;
      logic  es;
      int    want;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         l.push_back(mk(1, LW, 0, 8, 0, 0));
         l.push_back(mk(1, RT, 8, 1, 9, 0));
         l.push_back(mk(1, RT, 8, 1, 9, 0));
      end
      foreach (l[i]) begin
         drive(l[i], es);
         #1; checks++;
         if (stall_o !== es) begin
            fails++; $display("FAIL saturate[%0d] stall_o: got %b expected %b", i, stall_o, es);
         end
         @(posedge clk); #1; checks++;
         if (sb.size() == 0) begin
            fails++; $display("FAIL saturate[%0d] scoreboard: got empty queue expected entry", i);
         end else begin
            e = sb.pop_front();
            if (act() !== e) begin
               fails++; $display("FAIL saturate[%0d] outputs: got %h expected %h", i, act(), e);
            end
         end
         if (i % 3 == 2) begin
            want = (i / 3 + 1 > 3) ? 3 : i / 3 + 1;
            checks++;
            if (d2_cnt !== want[1:0]) begin
               fails++; $display("FAIL saturate_cnt2 pair %0d: got %0d expected %0d", i / 3, d2_cnt, want);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [9];
      stim_t s;
      exp_t  e;
      logic  es;
      ops[0] = RT; ops[1] = ADDI; ops[2] = SLTI; ops[3] = LW; ops[4] = SW;
      ops[5] = BEQ; ops[6] = BNE; ops[7] = JMP; ops[8] = BAD;
      for (int i = 0; i < 300; i++) begin
         s = mk(($urandom % 8) != 0, (i % 3 == 0) ? LW : ops[$urandom_range(0, 8)],
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom % 8) == 0);
         drive(s, es);
         #1; checks++;
         if (stall_o !== es) begin
            fails++; $display("FAIL b2b[%0d] stall_o: got %b expected %b", i, stall_o, es);
         end
         @(posedge clk); #1; checks++;
         if (sb.size() == 0) begin
            fails++; $display("FAIL b2b[%0d] scoreboard: got empty queue expected entry", i);
         end else begin
            e = sb.pop_front();
            if (act() !== e) begin
               fails++; $display("FAIL b2b[%0d] outputs: got %h expected %h", i, act(), e);
            end
         end
      end
   endtask

   initial begin
      m = '0;
      test_reset();
      test_load_use();
      test_rt_and_jump();
      test_flush();
      test_decode();
      test_saturation();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

endmodule

// File: doc/pipe_ctrl_decoder.md
Name: pipe_ctrl_decoder

Overview:
- ID-stage control unit for the pipelined MIPS datapath.
- Decodes the opcode of the IF/ID instruction into the full control-signal set, including the new bne and j modes.
- Registers the control set into the ID/EX stage and detects load-use hazards against the instruction currently in EX.
- Inserts bubbles on stall or flush and counts stall cycles for performance reporting.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, ALUOp width driven to ALU_Ctrl
REG_W, 5, register-address width
CNT_W, 16, stall-counter width (saturating)
HAZARD_EN, 1, 1 = load-use detection active; 0 = stall_o tied low, no hazard bubbles

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-low reset
valid_i  in  1  IF/ID holds a real instruction
instr_op_i  in  OP_W  opcode field [31:26]
rs_i  in  REG_W  rs field
rt_i  in  REG_W  rt field
rd_i  in  REG_W  rd field
flush_i  in  1  branch/jump taken in later stage; squash the ID instruction
stall_o  out  1  combinational; hold PC and IF/ID this cycle
valid_o  out  1  ID/EX entry valid
RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, Jump_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1 each  registered controls
ALUOp_o  out  ALUOP_W  registered ALU op class
wr_reg_o  out  REG_W  registered destination (RegDst ? rd : rt)
illegal_o  out  1  registered one-cycle flag: a valid, unflushed, unstalled instruction had an unknown opcode
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_i=0, asynchronous): all registered outputs 0, including valid_o, every control, ALUOp_o, wr_reg_o, illegal_o and stall_cnt_o. A reset mid-stall drops stall_o to 0 immediately, since the EX entry clears.
- Decode table. Unlisted signals are 0. ALUOp encodings: R=000, ADD=100, SLT=010, SUB=001.
  - R 000000: RegWrite, RegDst, ALUOp=000.
  - addi 001000: RegWrite, ALUSrc, ALUOp=100.
  - slti 001010: RegWrite, ALUSrc, ALUOp=010.
  - lw 100011: RegWrite, ALUSrc, MemRead, MemtoReg, ALUOp=100.
  - sw 101011: ALUSrc, MemWrite, ALUOp=100.
  - beq 000100: Branch, ALUOp=001.
  - bne 000101: Branch, BranchNe, ALUOp=001.
  - j 000010: Jump.
  - Any other opcode: all controls 0 (NOP), illegal.
- Source usage:
  - rs is used by every opcode except j.
  - rt is used by R, sw, beq, bne.
- Hazard (HAZARD_EN=1): stall_o = valid_i & valid_o & MemRead_o & wr_reg_o≠0 & ((rs used & rs_i==wr_reg_o) | (rt used & rt_i==wr_reg_o)) & ~flush_i.
- Next-state priority per rising edge:
  1. flush_i: load a bubble (valid_o=0, all controls 0, illegal_o=0).
  2. stall_o: load a bubble.
  3. valid_i=0: load a bubble.
  4. Otherwise: load the decoded set with valid_o=1; illegal_o=1 if the opcode is unknown.
- Latency: 1 cycle from the ID inputs to the registered outputs.
- A load-use stall lasts exactly 1 cycle: after the bubble, valid_o=0, so the hazard clears and the held instruction issues on the next edge.
- stall_cnt_o increments by 1 on every edge where stall_o=1 and holds at 2^CNT_W−1.
- Register $0 never produces a hazard.
- Simultaneous flush_i and hazard: flush wins; stall_o=0 and the counter does not increment.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J);
  - ALUOp localparams (ALUOP_R, ALUOP_ADD, ALUOP_SLT, ALUOP_SUB);
  - a packed control-bundle typedef.
- One sub-module, op_decode_comb: the purely combinational table. It maps opcode to the control bundle plus rs_used, rt_used and illegal.
- The top level holds the hazard logic, the ID/EX register and the counter.

Test Plan:
- Reset: assert rst_i=0 mid-clock with valid_o=1 -> every output 0 immediately, stall_cnt_o=0.
- lw $8,0($0) then add $9,$8,$1 -> cycle after lw: MemRead_o=1, wr_reg_o=8, stall_o=1. Next edge: valid_o=0. Following edge: RegDst_o=1, RegWrite_o=1, wr_reg_o=9. stall_cnt_o=1.
- lw $0 then add $9,$0,$0 -> stall_o stays 0.
- lw $8, then sw $8 (rt match) -> stall. lw $8, then j -> no stall.
- Hazard condition with flush_i=1 -> stall_o=0, bubble loaded, stall_cnt_o unchanged.
- bne 000101 -> Branch_o=1, BranchNe_o=1, ALUOp_o=001.
- Opcode 111111 with valid_i=1 -> illegal_o=1 for one cycle, all controls 0, valid_o=1.
- CNT_W=2, repeated lw-use pairs -> stall_cnt_o goes 1,2,3,3.
